// File: rtl/por_rst_seq.sv
// por_rst_seq: synchronises a POR pulse and releases NSTG active-low domain resets one gap apart
// Optional POR pulse-width measurement is enabled by defining POR_SEQ_WIDTH_CHECK_EN.
module por_rst_seq #(
    parameter int NSTG = 4,
    parameter int MINW = 1024
) (
    input  logic            osc_ck,
    input  logic            rsb,
    input  logic            por,
    input  logic            force_rst,
    input  logic [1:0]      gap_sel,
    output logic [NSTG-1:0] rst_outb,
    output logic            seq_done,
    output logic [15:0]     por_width,
    output logic            por_short
);
    localparam int SW = $clog2(NSTG);

    typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_e;

    state_e          state_q, state_d;
    logic            por_meta_q, por_s_q;
    logic [1:0]      gsel_q, gsel_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [SW-1:0]   stg_q, stg_d;
    logic [NSTG-1:0] rst_outb_q, rst_outb_d;
    logic            seq_done_q, seq_done_d;
    logic            last_gap;

    if (NSTG < 2 || NSTG > 8 || MINW < 1 || MINW > 65535) begin : g_param_chk
        $error("por_rst_seq: NSTG must be 2..8 and MINW 1..65535");
    end

    // gap-1 for gap = 16 << gsel is a run of (4 + gsel) ones
    assign last_gap = (cnt_q == (7'h7F >> (2'd3 - gsel_q)));

    // Sequencer: HOLD wins over everything, then HOLD->RELEASE, then staged release to DONE
    always_comb begin
        state_d    = state_q;
        gsel_d     = gsel_q;
        cnt_d      = cnt_q;
        stg_d      = stg_q;
        rst_outb_d = rst_outb_q;
        seq_done_d = seq_done_q;
        if (por_s_q || force_rst) begin
            state_d    = HOLD;
            cnt_d      = '0;
            stg_d      = '0;
            rst_outb_d = '0;
            seq_done_d = 1'b0;
        end else if (state_q == HOLD) begin
            state_d = RELEASE;
            gsel_d  = gap_sel;
            cnt_d   = '0;
            stg_d   = '0;
        end else if (state_q == RELEASE) begin
            cnt_d = last_gap ? 7'd0 : cnt_q + 7'd1;
            if (last_gap) begin
                rst_outb_d[stg_q] = 1'b1;
                stg_d             = stg_q + SW'(1);
                state_d           = (stg_q == SW'(NSTG - 1)) ? DONE : RELEASE;
                seq_done_d        = (stg_q == SW'(NSTG - 1));
            end
        end
    end

    // POR synchroniser and sequencer state; rsb clears everything asynchronously
    always_ff @(posedge osc_ck or negedge rsb) begin
        if (!rsb) begin
            por_meta_q <= 1'b0;
            por_s_q    <= 1'b0;
            state_q    <= HOLD;
            gsel_q     <= '0;
            cnt_q      <= '0;
            stg_q      <= '0;
            rst_outb_q <= '0;
            seq_done_q <= 1'b0;
        end else begin
            por_meta_q <= por;
            por_s_q    <= por_meta_q;
            state_q    <= state_d;
            gsel_q     <= gsel_d;
            cnt_q      <= cnt_d;
            stg_q      <= stg_d;
            rst_outb_q <= rst_outb_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign rst_outb = rst_outb_q;
    assign seq_done = seq_done_q;

`ifdef POR_SEQ_WIDTH_CHECK_EN
    logic        por_prev_q;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] por_width_q, por_width_d;
    logic        por_short_q, por_short_d;
    logic        por_fall;

    assign por_fall = !por_s_q && por_prev_q;

    // Width counter restarts at 1 on the first high cycle, saturates, and is captured on the fall
    always_comb begin
        wcnt_d      = por_s_q ? (por_prev_q ? ((&wcnt_q) ? wcnt_q : wcnt_q + 16'd1) : 16'd1) : wcnt_q;
        por_width_d = por_fall ? wcnt_q : por_width_q;
        por_short_d = por_fall ? (wcnt_q < 16'(MINW)) : por_short_q;
    end

    // Width measurement registers
    always_ff @(posedge osc_ck or negedge rsb) begin
        if (!rsb) begin
            por_prev_q  <= 1'b0;
            wcnt_q      <= '0;
            por_width_q <= '0;
            por_short_q <= 1'b0;
        end else begin
            por_prev_q  <= por_s_q;
            wcnt_q      <= wcnt_d;
            por_width_q <= por_width_d;
            por_short_q <= por_short_d;
        end
    end

    assign por_width = por_width_q;
    assign por_short = por_short_q;
`else
    assign por_width = '0;
    assign por_short = 1'b0;
`endif

endmodule

// File: tb/tb_por_rst_seq.sv
// tb_por_rst_seq: vector table, hand sequences and random stimulus against a timeline model
module tb_por_rst_seq;
    localparam int NSTG = 4;
    localparam int MINW = 1024;
`ifdef POR_SEQ_WIDTH_CHECK_EN
    localparam bit WCHK = 1'b1;
`else
    localparam bit WCHK = 1'b0;
`endif

    logic            osc_ck = 1'b0;
    logic            rsb = 1'b1;
    logic            por = 1'b0;
    logic            force_rst = 1'b0;
    logic [1:0]      gap_sel = 2'd0;
    logic [NSTG-1:0] rst_outb;
    logic            seq_done;
    logic [15:0]     por_width;
    logic            por_short;

    int vectors = 0;
    int miscompares = 0;

    por_rst_seq #(.NSTG(NSTG), .MINW(MINW)) dut (
        .osc_ck(osc_ck), .rsb(rsb), .por(por), .force_rst(force_rst), .gap_sel(gap_sel),
        .rst_outb(rst_outb), .seq_done(seq_done), .por_width(por_width), .por_short(por_short)
    );

    always #5 osc_ck = ~osc_ck;

    // Model: releases are a function of elapsed cycles since the sequence started
    bit m_s1, m_s2, m_hold, m_prev, m_short;
    int m_n, m_t0, m_gap, m_run, m_w;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_hold = 1; m_prev = 0; m_short = 0;
        m_t0 = 0; m_gap = 16; m_run = 0; m_w = 0;
    endtask

    function automatic logic [NSTG-1:0] m_rst();
        logic [NSTG-1:0] r;
        r = '0;
        for (int k = 0; k < NSTG; k++)
            if (!m_hold && (m_n - m_t0) >= (k + 1) * m_gap) r[k] = 1'b1;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d..%0d", nm, $time, act, lo, hi);
        end
    endtask

    task automatic tick();
        bit ps;
        @(posedge osc_ck);
        ps = m_s2;
        m_n++;
        if (ps || force_rst) m_hold = 1;
        else if (m_hold) begin
            m_hold = 0;
            m_t0   = m_n;
            m_gap  = 16 << gap_sel;
        end
        if (WCHK) begin
            if (ps) m_run = m_prev ? ((m_run < 65535) ? m_run + 1 : 65535) : 1;
            else if (m_prev) begin
                m_w     = m_run;
                m_short = (m_run < MINW);
            end
        end
        m_prev = ps;
        m_s2   = m_s1;
        m_s1   = por;
        #1;
        check("model_rst_outb", rst_outb, m_rst());
        check("model_seq_done", seq_done, !m_hold && (m_n - m_t0) >= NSTG * m_gap);
        check("model_por_width", por_width, m_w);
        check("model_por_short", por_short, m_short);
    endtask

    typedef struct {
        logic       por;
        logic       frc;
        logic [1:0] gs;
        int         n;
        logic [3:0] rst;
        logic       done;
    } vec_t;

    vec_t tbl[35];

    initial begin
        tbl = '{
            '{0,0,0,  1,4'b0000,0}, '{0,0,0, 15,4'b0000,0}, '{0,0,0,  1,4'b0001,0},
            '{0,0,0, 16,4'b0011,0}, '{0,0,0, 15,4'b0011,0}, '{0,0,0,  1,4'b0111,0},
            '{0,0,0, 15,4'b0111,0}, '{0,0,0,  1,4'b1111,1}, '{0,1,0,  1,4'b0000,0},
            '{0,0,2,  1,4'b0000,0}, '{0,0,2, 63,4'b0000,0}, '{0,0,2,  1,4'b0001,0},
            '{0,0,2, 64,4'b0011,0}, '{0,1,2,  1,4'b0000,0}, '{0,0,2,  1,4'b0000,0},
            '{0,0,2, 64,4'b0001,0}, '{0,0,3, 64,4'b0011,0}, '{0,0,3,128,4'b1111,1},
            '{0,1,0,  1,4'b0000,0}, '{0,0,0,  1,4'b0000,0}, '{0,0,3, 16,4'b0001,0},
            '{0,0,3, 32,4'b0111,0}, '{0,0,3, 16,4'b1111,1}, '{0,1,3,  1,4'b0000,0},
            '{0,0,3,  1,4'b0000,0}, '{0,0,0,127,4'b0000,0}, '{0,0,0,  1,4'b0001,0},
            '{0,0,0,384,4'b1111,1}, '{1,0,0,  2,4'b1111,1}, '{1,0,0,  1,4'b0000,0},
            '{0,0,0,  2,4'b0000,0}, '{0,0,0,  1,4'b0000,0}, '{0,0,0, 15,4'b0000,0},
            '{0,0,0,  1,4'b0001,0}, '{0,0,0, 48,4'b1111,1}
        };
        model_reset();
        m_n = 0;
        #1 rsb = 1'b0;
        #10;
        check("reset_rst_outb", rst_outb, 0);
        check("reset_seq_done", seq_done, 0);
        check("reset_por_width", por_width, 0);
        check("reset_por_short", por_short, 0);
        #1 rsb = 1'b1;

        foreach (tbl[i]) begin
            por = tbl[i].por; force_rst = tbl[i].frc; gap_sel = tbl[i].gs;
            repeat (tbl[i].n) tick();
            check($sformatf("tbl%0d_rst_outb", i), rst_outb, tbl[i].rst);
            check($sformatf("tbl%0d_seq_done", i), seq_done, tbl[i].done);
        end
        force_rst = 1'b0;

        // Long POR from DONE: outputs drop 3 cycles after rise, width measured, sequence restarts
        repeat (80) tick();
        por = 1'b1;
        repeat (2) tick();
        check("por2000_lat2_rst_outb", rst_outb, 4'b1111);
        tick();
        check("por2000_lat3_rst_outb", rst_outb, 0);
        repeat (1997) tick();
        por = 1'b0;
        repeat (4) tick();
        check_rng("por2000_width", por_width, WCHK ? 1999 : 0, WCHK ? 2001 : 0);
        check("por2000_short", por_short, 0);
        repeat (70) tick();
        check("por2000_restart_done", seq_done, 1);

        por = 1'b1;
        repeat (100) tick();
        por = 1'b0;
        repeat (4) tick();
        check_rng("por100_width", por_width, WCHK ? 99 : 0, WCHK ? 101 : 0);
        check("por100_short", por_short, WCHK);

        por = 1'b1;
        repeat (70000) tick();
        por = 1'b0;
        repeat (4) tick();
        check("por70000_width", por_width, WCHK ? 16'hFFFF : 16'h0);
        check("por70000_short", por_short, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) por = ~por;
            force_rst = ($urandom_range(0, 149) == 0);
            gap_sel   = 2'($urandom);
            tick();
        end

        // Asynchronous rsb assertion in the middle of a sequence
        por = 1'b0; force_rst = 1'b1; gap_sel = 2'd0;
        repeat (4) tick();
        force_rst = 1'b0;
        repeat (40) tick();
        check("pre_rsb_rst_outb", rst_outb, 4'b0011);
        #2 rsb = 1'b0;
        #1;
        model_reset();
        check("rsb_async_rst_outb", rst_outb, 0);
        check("rsb_async_seq_done", seq_done, 0);
        check("rsb_async_por_width", por_width, 0);
        check("rsb_async_por_short", por_short, 0);
        #2 rsb = 1'b1;
        repeat (65) tick();
        check("post_rsb_done", seq_done, 1);
        check("post_rsb_rst_outb", rst_outb, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
